// File: rtl/riscv_mem_pkg.sv
// Shared memory-stage definitions for the RISC-V core: load op codes, the load
// engine state type and the load decode helpers.
package riscv_mem_pkg;

  // Load op codes carried on read_write
  localparam logic [3:0] LB  = 4'b1000;
  localparam logic [3:0] LH  = 4'b1001;
  localparam logic [3:0] LW  = 4'b1010;
  localparam logic [3:0] LBU = 4'b1100;
  localparam logic [3:0] LHU = 4'b1101;

  typedef enum logic [1:0] {
    LoadIdle = 2'd0,
    LoadReq  = 2'd1,
    LoadResp = 2'd2
  } load_state_e;

  // Shared with the hazard/stall logic so both agree on what counts as a load
  function automatic logic is_load(input logic [3:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if ((op == LH) || (op == LHU)) mis = off[0];
    else if (op == LW)             mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Bus bundle of the load unit: the EXE-side issue signals, the data-memory
// req/ack handshake and the writeback/status outputs.
//   master : view of the load unit itself
//   slave  : view of its environment (EXE stage, data memory, writeback)
interface load_unit_if;
  logic        valid_in;
  logic [3:0]  read_write;
  logic [31:0] addr;
  logic [4:0]  rd_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_rd;
  logic        misalign;
  logic        load_err;

  modport master (
    input  valid_in, read_write, addr, rd_in, mem_ack, mem_rdata,
    output mem_req, mem_addr, mem_stall, load_valid, load_data, load_rd, misalign, load_err
  );

  modport slave (
    output valid_in, read_write, addr, rd_in, mem_ack, mem_rdata,
    input  mem_req, mem_addr, mem_stall, load_valid, load_data, load_rd, misalign, load_err
  );
endinterface

// File: rtl/load_extend.sv
// Combinational load data extraction: selects the addressed byte/half from a
// little-endian memory word and sign- or zero-extends it.
//   op       : load op code
//   byte_off : byte address bits [1:0]
//   word     : memory read word
//   data     : extended 32-bit result
module load_extend
  import riscv_mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = word[7:0];
    case (byte_off)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = byte_off[1] ? word[31:16] : word[15:0];

    data = word;
    case (op)
      LB:      data = {{24{sel_byte[7]}}, sel_byte};
      LH:      data = {{16{sel_half[15]}}, sel_half};
      LBU:     data = {24'd0, sel_byte};
      LHU:     data = {16'd0, sel_half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Memory-stage load engine. Accepts a load from EXE, performs a req/ack read
// of data memory, extends the addressed byte/half/word and returns it with its
// destination register. Holds the pipeline (mem_stall) while the load is in
// flight; misaligned loads are dropped with a one-cycle misalign pulse.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : load_unit_if master (issue, memory handshake, writeback)
// Optional build macro LOAD_TIMEOUT_EN: abort a request after TIMEOUT_CYCLES
// cycles without mem_ack and pulse load_err; otherwise load_err is tied low.
module load_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  load_unit_if.master bus
);

  load_state_e state_q, state_d;
  logic [31:0] addr_q;
  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic [31:0] data_q;
  logic [4:0]  load_rd_q;
  logic        misalign_q;

  logic        accept;
  logic        mis;
  logic        accept_ok;
  logic        resp_fire;
  logic        timeout;
  logic [31:0] ext_data;

  assign accept    = (state_q == LoadIdle) && bus.valid_in && is_load(bus.read_write);
  assign mis       = is_misaligned(bus.read_write, bus.addr[1:0]);
  assign accept_ok = accept && !mis;
  assign resp_fire = (state_q == LoadReq) && bus.mem_ack;

  load_extend u_extend (
    .op       (op_q),
    .byte_off (addr_q[1:0]),
    .word     (bus.mem_rdata),
    .data     (ext_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LoadIdle: if (accept_ok) state_d = LoadReq;
      // ack beats a simultaneous timeout
      LoadReq: begin
        if (bus.mem_ack)  state_d = LoadResp;
        else if (timeout) state_d = LoadIdle;
      end
      LoadResp: state_d = LoadIdle;
      default:  state_d = LoadIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LoadIdle;
      addr_q     <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      data_q     <= '0;
      load_rd_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= accept && mis;
      if (accept) begin
        addr_q <= bus.addr;
        op_q   <= bus.read_write;
        rd_q   <= bus.rd_in;
      end
      // Result registers only move on completion so they hold between loads
      if (resp_fire) begin
        data_q    <= ext_data;
        load_rd_q <= rd_q;
      end
    end
  end

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // cnt_q counts completed REQ cycles; the TIMEOUT_CYCLES-th one expires
  assign timeout = (state_q == LoadReq) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout && !bus.mem_ack;
      if ((state_q == LoadReq) && !bus.mem_ack && !timeout) cnt_q <= cnt_q + 1'b1;
      else                                                 cnt_q <= '0;
    end
  end

  assign bus.load_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign bus.load_err       = 1'b0;
`endif

  assign bus.mem_req    = (state_q == LoadReq);
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_stall  = accept_ok || (state_q == LoadReq);
  assign bus.load_valid = (state_q == LoadResp);
  assign bus.load_data  = data_q;
  assign bus.load_rd    = load_rd_q;
  assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed vector table, randomized loads
// against a behavioural model, and hand sequences for reset and timeout.
module tb_load_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_unit_if bus ();

  load_unit #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] last_data = 32'd0;
  logic [4:0]  last_rd   = 5'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          waits;
    bit          ld;
    bit          mis;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model
  function automatic bit ref_is_load(input logic [3:0] op);
    return op inside {4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101};
  endfunction

  function automatic bit ref_misaligned(input logic [3:0] op, input logic [31:0] a);
    int unsigned size;
    case (op)
      4'b1001, 4'b1101: size = 2;
      4'b1010:          size = 4;
      default:          size = 1;
    endcase
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] ref_data(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    int unsigned k;
    k  = a[1:0];
    sh = w >> (8 * k);
    case (op)
      4'b1000: return int'(byte'(sh[7:0]));
      4'b1001: return int'(shortint'(sh[15:0]));
      4'b1100: return sh & 32'h0000_00FF;
      4'b1101: return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  // Issue one operation and check its full cycle-by-cycle behaviour
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [4:0] rd, input logic [31:0] rdata, input int waits,
                       input bit exp_ld, input bit exp_mis, input logic [31:0] exp_data);
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    bus.valid_in = 1'b1; bus.read_write = op; bus.addr = a; bus.rd_in = rd; bus.mem_ack = 1'b0;
    @(negedge clk);
    if (bus.mem_stall) stalls++;
    chk({tag, " mem_req@accept"}, bus.mem_req, 0);
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.read_write = 4'b0000; bus.addr = $urandom;
    if (!(exp_ld && !exp_mis)) begin
      // stray ack while idle must be ignored
      bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
      @(negedge clk);
      if (bus.mem_stall) stalls++;
      chk({tag, " misalign"}, bus.misalign, exp_mis);
      chk({tag, " mem_req"}, bus.mem_req, 0);
      chk({tag, " load_valid"}, bus.load_valid, 0);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      chk({tag, " misalign end"}, bus.misalign, 0);
      chk({tag, " mem_req later"}, bus.mem_req, 0);
      chk({tag, " load_valid later"}, bus.load_valid, 0);
      chk({tag, " load_data hold"}, bus.load_data, last_data);
      chk({tag, " load_rd hold"}, bus.load_rd, last_rd);
      chk({tag, " stall cycles"}, stalls, 0);
    end else begin
      for (int w = 0; w <= waits; w++) begin
        bus.mem_ack   = (w == waits);
        bus.mem_rdata = (w == waits) ? rdata : $urandom;
        @(negedge clk);
        if (bus.mem_stall) stalls++;
        chk({tag, " mem_req"}, bus.mem_req, 1);
        chk({tag, " mem_addr"}, bus.mem_addr, a & 32'hFFFF_FFFC);
        chk({tag, " early valid"}, bus.load_valid, 0);
        @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
      // load offered during RESP must not be taken
      bus.valid_in = 1'b1; bus.read_write = 4'b1010; bus.addr = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      if (bus.mem_stall) stalls++;
      chk({tag, " load_valid"}, bus.load_valid, 1);
      chk({tag, " load_data"}, bus.load_data, exp_data);
      chk({tag, " load_rd"}, bus.load_rd, rd);
      chk({tag, " load_err"}, bus.load_err, 0);
      last_data = exp_data;
      last_rd   = rd;
      @(posedge clk); #1;
      bus.valid_in = 1'b0; bus.read_write = 4'b0000;
      @(negedge clk);
      chk({tag, " valid pulse"}, bus.load_valid, 0);
      chk({tag, " resp op ignored"}, bus.mem_req, 0);
      chk({tag, " data hold"}, bus.load_data, exp_data);
      chk({tag, " stall cycles"}, stalls, waits + 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes [5];
    logic [3:0] op;
    logic [31:0] a, w;
    logic [4:0] rd;
    int waits;

    codes[0] = 4'b1000; codes[1] = 4'b1001; codes[2] = 4'b1010;
    codes[3] = 4'b1100; codes[4] = 4'b1101;

    vecs[0]  = '{4'b1000, 32'h103, 5'd1,  32'h80FF_1234, 0, 1, 0, 32'hFFFF_FF80};
    vecs[1]  = '{4'b1101, 32'h202, 5'd9,  32'h8001_0000, 3, 1, 0, 32'h0000_8001};
    vecs[2]  = '{4'b1010, 32'h006, 5'd2,  32'h1111_1111, 0, 1, 1, 32'h0};
    vecs[3]  = '{4'b0010, 32'h100, 5'd3,  32'h2222_2222, 0, 0, 0, 32'h0};
    vecs[4]  = '{4'b1001, 32'h002, 5'd3,  32'h8001_0000, 1, 1, 0, 32'hFFFF_8001};
    vecs[5]  = '{4'b1100, 32'h001, 5'd4,  32'h0000_F200, 0, 1, 0, 32'h0000_00F2};
    vecs[6]  = '{4'b1010, 32'h010, 5'd5,  32'hDEAD_BEEF, 2, 1, 0, 32'hDEAD_BEEF};
    vecs[7]  = '{4'b1001, 32'h001, 5'd6,  32'h3333_3333, 0, 1, 1, 32'h0};
    vecs[8]  = '{4'b1101, 32'h003, 5'd7,  32'h4444_4444, 0, 1, 1, 32'h0};
    vecs[9]  = '{4'b1000, 32'h000, 5'd6,  32'h1234_567F, 0, 1, 0, 32'h0000_007F};
    vecs[10] = '{4'b1100, 32'h002, 5'd7,  32'h00AB_0000, 1, 1, 0, 32'h0000_00AB};
    vecs[11] = '{4'b1011, 32'h004, 5'd8,  32'h5555_5555, 0, 0, 0, 32'h0};
    vecs[12] = '{4'b1000, 32'h102, 5'd8,  32'h0080_0000, 0, 1, 0, 32'hFFFF_FF80};
    vecs[13] = '{4'b1010, 32'h001, 5'd10, 32'h6666_6666, 0, 1, 1, 32'h0};

    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.read_write = 4'b0; bus.addr = 32'h0; bus.rd_in = 5'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_stall", bus.mem_stall, 0);
    chk("reset load_valid", bus.load_valid, 0);
    chk("reset load_data", bus.load_data, 0);
    chk("reset load_rd", bus.load_rd, 0);
    chk("reset misalign", bus.misalign, 0);
    chk("reset load_err", bus.load_err, 0);

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].rd, vecs[i].rdata,
            vecs[i].waits, vecs[i].ld, vecs[i].mis, vecs[i].data);

    for (int n = 0; n < 40; n++) begin
      op    = ($urandom_range(0, 7) < 5) ? codes[$urandom_range(0, 4)] : 4'($urandom_range(0, 15));
      a     = $urandom;
      w     = $urandom;
      rd    = 5'($urandom_range(0, 31));
      waits = $urandom_range(0, 3);
      do_op($sformatf("rand%0d", n), op, a, rd, w, waits, ref_is_load(op),
            ref_misaligned(op, a), ref_data(op, a, w));
    end

    // Reset while a request is outstanding
    @(posedge clk); #1;
    bus.valid_in = 1'b1; bus.read_write = 4'b1010; bus.addr = 32'h44; bus.rd_in = 5'd7;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.read_write = 4'b0;
    @(negedge clk);
    chk("rst seq mem_req", bus.mem_req, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst seq mem_req after", bus.mem_req, 0);
    chk("rst seq mem_stall after", bus.mem_stall, 0);
    chk("rst seq mem_addr after", bus.mem_addr, 0);
    chk("rst seq load_data after", bus.load_data, 0);
    chk("rst seq load_rd after", bus.load_rd, 0);
    last_data = 32'h0;
    last_rd   = 5'd0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst seq no load_valid", bus.load_valid, 0);
    chk("rst seq no mem_req", bus.mem_req, 0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    do_op("post reset", 4'b1001, 32'h0000_0802, 5'd12, 32'hFEDC_0000, 0, 1, 0, 32'hFFFF_FEDC);

`ifdef LOAD_TIMEOUT_EN
    // No ack: request abandoned after four REQ cycles
    @(posedge clk); #1;
    bus.valid_in = 1'b1; bus.read_write = 4'b1000; bus.addr = 32'h123; bus.rd_in = 5'd3;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.read_write = 4'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("timeout mem_req c%0d", c), bus.mem_req, 1);
      chk($sformatf("timeout load_err c%0d", c), bus.load_err, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("timeout mem_req dropped", bus.mem_req, 0);
    chk("timeout load_err pulse", bus.load_err, 1);
    chk("timeout no load_valid", bus.load_valid, 0);
    chk("timeout no stall", bus.mem_stall, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("timeout load_err single", bus.load_err, 0);
    do_op("after timeout", 4'b1000, 32'h0000_0123, 5'd3, 32'h7F00_0000, 0, 1, 0, 32'h0000_007F);
    do_op("ack at expiry", 4'b1100, 32'h0000_0130, 5'd4, 32'h0000_00C3, 3, 1, 0, 32'h0000_00C3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
